// File: rtl/bht_gshare_pkg.sv
// bht_gshare_pkg: shared types and helpers for the gshare direction predictor.
//   bht_cnt_t   - 2-bit saturating counter (bit 1 is the predicted direction)
//   BHT_CNT_RST - weakly not-taken value loaded by reset and by the flush sweep
//   bht_state_e - flush sweeper states
//   sat_update  - next value of a counter given the resolved direction
package bht_gshare_pkg;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t BHT_CNT_RST = 2'b01;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } bht_state_e;

   // Move one step toward the resolved direction, holding at either end.
   function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != 2'b11) nxt = cnt + 2'd1;
      end else begin
         if (cnt != 2'b00) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bht_gshare_flush_fsm.sv
// bht_gshare_flush_fsm: walks the counter table once after a flush, one entry
// per cycle, so the table can be reinitialised through a single write port.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   flush_i       - start (or restart from entry 0) a sweep
//   state_o       - current sweeper state (debug visibility)
//   busy_o        - sweep in progress
//   wr_en_o       - write BHT_CNT_RST to entry wr_idx_o this cycle
//   wr_idx_o      - entry being cleared
module bht_gshare_flush_fsm
   import bht_gshare_pkg::*;
#(
   parameter int BHT_ENTRIES = 128,
   parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   output bht_state_e       state_o,
   output logic             busy_o,
   output logic             wr_en_o,
   output logic [IDX_W-1:0] wr_idx_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_ENTRIES - 1);

   bht_state_e       state_q;
   logic [IDX_W-1:0] ptr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_i) begin
                  state_q <= SWEEP;
                  ptr_q   <= '0;
               end
            end
            SWEEP: begin
               // A new flush restarts the walk; the entry at ptr_q is still
               // written this cycle, which is harmless.
               if (flush_i) begin
                  ptr_q <= '0;
               end else if (ptr_q == LAST_IDX) begin
                  state_q <= IDLE;
                  ptr_q   <= '0;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ptr_q   <= '0;
            end
         endcase
      end
   end

   assign state_o  = state_q;
   assign busy_o   = (state_q == SWEEP);
   assign wr_en_o  = (state_q == SWEEP);
   assign wr_idx_o = ptr_q;

endmodule

// File: rtl/bht_gshare.sv
// bht_gshare: gshare branch direction predictor.
// Zero-latency prediction from a table of 2-bit counters indexed by
// pc[PC_LSB +: HIST_LEN] XOR global history. The speculative GHR shifts in
// each accepted prediction and is restored from the branch's checkpoint on a
// mispredict. A flush reinitialises the table one entry per cycle.
// Optional build macro: BHT_GSHARE_PERF_CNT_EN enables the two perf counters;
// without it both perf outputs are tied to zero.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   flush_i                   - start a table sweep
//   pred_valid_i, pred_pc_i   - prediction request and fetch PC
//   pred_ready_o              - predictor available (low during a sweep)
//   pred_taken_o, pred_hist_o - predicted direction, GHR checkpoint
//   upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_mispredict_i
//                             - branch resolution
//   busy_o                    - sweep in progress
//   perf_pred_cnt_o, perf_mispred_cnt_o - accepted predictions, mispredicts
// Handshake: a prediction is accepted in any cycle where pred_valid_i and
// pred_ready_o are both high; pred_taken_o/pred_hist_o are valid that cycle.
// Resolutions have no backpressure and are dropped while a sweep runs.
module bht_gshare
   import bht_gshare_pkg::*;
#(
   parameter int VLEN        = 64,
   parameter int BHT_ENTRIES = 128,
   parameter int PC_LSB      = 1,
   parameter int HIST_LEN    = $clog2(BHT_ENTRIES)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                pred_valid_i,
   input  logic [VLEN-1:0]     pred_pc_i,
   output logic                pred_ready_o,
   output logic                pred_taken_o,
   output logic [HIST_LEN-1:0] pred_hist_o,
   input  logic                upd_valid_i,
   input  logic [VLEN-1:0]     upd_pc_i,
   input  logic [HIST_LEN-1:0] upd_hist_i,
   input  logic                upd_taken_i,
   input  logic                upd_mispredict_i,
   output logic                busy_o,
   output logic [31:0]         perf_pred_cnt_o,
   output logic [31:0]         perf_mispred_cnt_o
);

   bht_cnt_t            cnt_q [BHT_ENTRIES];
   logic [HIST_LEN-1:0] ghr_q;
   logic [HIST_LEN-1:0] pred_idx;
   logic [HIST_LEN-1:0] upd_idx;
   logic [HIST_LEN-1:0] sweep_idx;
   logic                sweep_wr;
   bht_state_e          fsm_state;
   logic                pred_accept;
   logic                upd_mispred;
   logic                upd_en;
   logic                unused_pc_bits;

   bht_gshare_flush_fsm #(
      .BHT_ENTRIES (BHT_ENTRIES),
      .IDX_W       (HIST_LEN)
   ) u_flush_fsm (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush_i  (flush_i),
      .state_o  (fsm_state),
      .busy_o   (busy_o),
      .wr_en_o  (sweep_wr),
      .wr_idx_o (sweep_idx)
   );

   assign pred_idx = pred_pc_i[PC_LSB +: HIST_LEN] ^ ghr_q;
   assign upd_idx  = upd_pc_i[PC_LSB +: HIST_LEN] ^ upd_hist_i;

   assign pred_ready_o = ~busy_o;
   assign pred_taken_o = pred_ready_o & cnt_q[pred_idx][1];
   assign pred_hist_o  = ghr_q;

   assign pred_accept = pred_valid_i & pred_ready_o;
   assign upd_mispred = upd_valid_i & upd_mispredict_i;
   // A same-cycle flush wins over training.
   assign upd_en      = upd_valid_i & (fsm_state == IDLE) & ~flush_i;

   // PC bits outside the index window are intentionally ignored.
   assign unused_pc_bits = ^{pred_pc_i, upd_pc_i};

   // Counter table: the read above sees the registered value, so a same-cycle
   // update to the predicted entry is only visible from the next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= BHT_CNT_RST;
      end else if (sweep_wr) begin
         cnt_q[sweep_idx] <= BHT_CNT_RST;
      end else if (upd_en) begin
         cnt_q[upd_idx] <= sat_update(cnt_q[upd_idx], upd_taken_i);
      end
   end

   // Speculative history: flush clears, mispredict restores from the
   // checkpoint, otherwise an accepted prediction shifts in its direction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ghr_q <= '0;
      end else if (flush_i) begin
         ghr_q <= '0;
      end else if (upd_mispred) begin
         ghr_q <= {upd_hist_i[HIST_LEN-2:0], upd_taken_i};
      end else if (pred_accept) begin
         ghr_q <= {ghr_q[HIST_LEN-2:0], pred_taken_o};
      end
   end

`ifdef BHT_GSHARE_PERF_CNT_EN
   logic [31:0] perf_pred_q;
   logic [31:0] perf_mispred_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_pred_q    <= '0;
         perf_mispred_q <= '0;
      end else begin
         if (pred_accept) perf_pred_q    <= perf_pred_q + 32'd1;
         if (upd_mispred) perf_mispred_q <= perf_mispred_q + 32'd1;
      end
   end

   assign perf_pred_cnt_o    = perf_pred_q;
   assign perf_mispred_cnt_o = perf_mispred_q;
`else
   assign perf_pred_cnt_o    = '0;
   assign perf_mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bht_gshare.sv
module tb_bht_gshare;

   localparam logic [63:0] PC_A = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        pred_valid = 1'b0;
   logic [63:0] pred_pc = '0;
   logic        pred_ready;
   logic        pred_taken;
   logic [6:0]  pred_hist;
   logic        upd_valid = 1'b0;
   logic [63:0] upd_pc = '0;
   logic [6:0]  upd_hist = '0;
   logic        upd_taken = 1'b0;
   logic        upd_mispredict = 1'b0;
   logic        busy;
   logic [31:0] perf_pred;
   logic [31:0] perf_mispred;

   int total = 0;
   int bad = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   bht_gshare dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .flush_i            (flush),
      .pred_valid_i       (pred_valid),
      .pred_pc_i          (pred_pc),
      .pred_ready_o       (pred_ready),
      .pred_taken_o       (pred_taken),
      .pred_hist_o        (pred_hist),
      .upd_valid_i        (upd_valid),
      .upd_pc_i           (upd_pc),
      .upd_hist_i         (upd_hist),
      .upd_taken_i        (upd_taken),
      .upd_mispredict_i   (upd_mispredict),
      .busy_o             (busy),
      .perf_pred_cnt_o    (perf_pred),
      .perf_mispred_cnt_o (perf_mispred)
   );

   // ---------------- reference model ----------------
   // Table of counter values 0..3, history as an integer, sweep as a
   // count of remaining cycles plus the next position to clear.
   int m_cnt[128];
   int m_ghr;
   int m_sweep_left;
   int m_sweep_pos;
   int m_pred_cnt;
   int m_mis_cnt;

   function automatic void model_reset();
      for (int i = 0; i < 128; i++) m_cnt[i] = 1;
      m_ghr        = 0;
      m_sweep_left = 0;
      m_sweep_pos  = 0;
      m_pred_cnt   = 0;
      m_mis_cnt    = 0;
   endfunction

   function automatic int pc_bits(input logic [63:0] pc);
      return int'((pc >> 1) % 128);
   endfunction

   function automatic logic [31:0] exp_perf(input int v);
`ifdef BHT_GSHARE_PERF_CNT_EN
      return 32'(v);
`else
      return (v < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic act_taken;
   logic [6:0] act_hist;
   logic act_busy;

   // ---------------- driver: one cycle ----------------
   task automatic step(input logic pv, input logic [63:0] pc,
                       input logic uv, input logic [63:0] upc, input logic [6:0] uh,
                       input logic ut, input logic um, input logic fl);
      int  pidx, uidx, v;
      logic e_ready, e_taken;
      @(negedge clk);
      pred_valid = pv; pred_pc = pc;
      upd_valid = uv; upd_pc = upc; upd_hist = uh; upd_taken = ut; upd_mispredict = um;
      flush = fl;
      #1;
      e_ready = (m_sweep_left == 0);
      pidx    = pc_bits(pc) ^ m_ghr;
      e_taken = e_ready && (m_cnt[pidx] >= 2);
      check("pred_ready", 64'(pred_ready), 64'(e_ready));
      check("busy", 64'(busy), 64'(!e_ready));
      check("pred_taken", 64'(pred_taken), 64'(e_taken));
      check("pred_hist", 64'(pred_hist), 64'(m_ghr));
      act_taken = pred_taken;
      act_hist  = pred_hist;
      act_busy  = busy;
      // advance model to the state after this clock edge
      if (pv && e_ready) m_pred_cnt++;
      if (uv && um) m_mis_cnt++;
      if (m_sweep_left > 0) begin
         m_cnt[m_sweep_pos] = 1;
         m_sweep_pos++;
         m_sweep_left--;
      end else if (uv && !fl) begin
         uidx = pc_bits(upc) ^ int'(uh);
         v = m_cnt[uidx] + (ut ? 1 : -1);
         m_cnt[uidx] = (v > 3) ? 3 : (v < 0) ? 0 : v;
      end
      if (fl) begin
         m_sweep_left = 128;
         m_sweep_pos  = 0;
      end
      if (fl) m_ghr = 0;
      else if (uv && um) m_ghr = (int'(uh) * 2 + int'(ut)) % 128;
      else if (pv && e_ready) m_ghr = (m_ghr * 2 + int'(e_taken)) % 128;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        pv;
      logic [63:0] pc;
      logic        uv;
      logic [63:0] upc;
      logic [6:0]  uh;
      logic        ut;
      logic        um;
      logic        exp_taken;
      logic [6:0]  exp_hist;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic pv, input logic [63:0] pc, input logic uv,
                               input logic [63:0] upc, input logic [6:0] uh, input logic ut,
                               input logic um, input logic et, input logic [6:0] eh);
      vec_t v;
      v.pv = pv; v.pc = pc; v.uv = uv; v.upc = upc; v.uh = uh; v.ut = ut; v.um = um;
      v.exp_taken = et; v.exp_hist = eh;
      return v;
   endfunction

   int n_busy, n_after, restart_seen;

   initial begin
      // predict on an untrained table
      vecs[0]  = mk(1, PC_A,       0, 0,           0, 0, 0, 0, 0);
      // train idx 0 toward taken; saturation keeps it at 3
      vecs[1]  = mk(0, PC_A,       1, PC_A,        0, 1, 0, 0, 0);
      vecs[2]  = mk(0, PC_A,       1, PC_A,        0, 1, 0, 1, 0);
      vecs[3]  = mk(0, PC_A,       1, PC_A,        0, 1, 0, 1, 0);
      vecs[4]  = mk(0, PC_A,       1, PC_A,        0, 0, 0, 1, 0);
      vecs[5]  = mk(0, PC_A,       0, 0,           0, 0, 0, 1, 0);
      // three taken accepts build GHR 0000111
      vecs[6]  = mk(1, PC_A,       0, 0,           0, 0, 0, 1, 7'h00);
      vecs[7]  = mk(1, PC_A + 2,   0, 0,           0, 0, 0, 1, 7'h01);
      vecs[8]  = mk(1, PC_A + 6,   0, 0,           0, 0, 0, 1, 7'h03);
      // accept plus mispredict in one cycle: restore wins
      vecs[9]  = mk(1, PC_A + 14,  1, PC_A + 64,   1, 0, 1, 1, 7'h07);
      vecs[10] = mk(0, PC_A + 4,   0, 0,           0, 0, 0, 1, 7'h02);
      // same-index predict/update: old value first, new value next cycle
      vecs[11] = mk(0, PC_A + 14,  1, PC_A + 10,   0, 1, 0, 0, 7'h02);
      vecs[12] = mk(0, PC_A + 14,  0, 0,           0, 0, 0, 1, 7'h02);
      vecs[13] = mk(0, PC_A + 14,  1, PC_A + 128,  2, 1, 1, 1, 7'h02);
      vecs[14] = mk(0, PC_A,       0, 0,           0, 0, 0, 1, 7'h05);

      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", 64'(pred_ready), 64'd1);
      check("rst_taken", 64'(pred_taken), 64'd0);
      check("rst_hist", 64'(pred_hist), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_perf_pred", 64'(perf_pred), 64'd0);
      check("rst_perf_mis", 64'(perf_mispred), 64'd0);

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].pv, vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].uh,
              vecs[i].ut, vecs[i].um, 1'b0);
         check($sformatf("vec%0d_taken", i), 64'(act_taken), 64'(vecs[i].exp_taken));
         check($sformatf("vec%0d_hist", i), 64'(act_hist), 64'(vecs[i].exp_hist));
      end
      #1;
      check("perf_pred_5", 64'(perf_pred), 64'(exp_perf(5)));
      check("perf_mis_2", 64'(perf_mispred), 64'(exp_perf(2)));

      // flush: busy for exactly 128 cycles, predictions blocked
      step(1, PC_A, 0, 0, 0, 0, 0, 1);
      n_busy = 0;
      while (n_busy < 400) begin
         step(1, PC_A, 1, PC_A, 0, 1, 0, 0);
         if (!act_busy) break;
         n_busy++;
      end
      check("sweep_len", 64'(n_busy), 64'd128);
      // the first non-busy step above was a prediction on a cleared table
      check("post_flush_taken", 64'(act_taken), 64'd0);
      check("post_flush_hist", 64'(act_hist), 64'd0);

      // flush, then restart on sweep cycle 60
      step(0, PC_A, 0, 0, 0, 0, 0, 1);
      n_busy = 0; n_after = 0; restart_seen = 0;
      while (n_busy < 400) begin
         step(1, PC_A, 0, 0, 0, 0, 0, (n_busy == 60));
         if (!act_busy) break;
         if (restart_seen != 0) n_after++;
         if (n_busy == 60) restart_seen = 1;
         n_busy++;
      end
      check("restart_after_len", 64'(n_after), 64'd128);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] rpc, rupc;
         rpc  = PC_A + 64'($urandom_range(0, 63)) * 2 + (64'($urandom_range(0, 3)) << 20);
         rupc = PC_A + 64'($urandom_range(0, 63)) * 2;
         step(1'($urandom_range(0, 1)), rpc,
              1'($urandom_range(0, 1)), rupc, 7'($urandom_range(0, 127)),
              1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 299) == 0));
      end
      #1;
      check("perf_pred_rand", 64'(perf_pred), 64'(exp_perf(m_pred_cnt)));
      check("perf_mis_rand", 64'(perf_mispred), 64'(exp_perf(m_mis_cnt)));

      // reset in the middle of a sweep
      step(0, PC_A, 0, 0, 0, 0, 0, 1);
      repeat (20) step(0, PC_A, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_ready", 64'(pred_ready), 64'd1);
      check("midrst_perf", 64'(perf_pred), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) begin
         step(1, PC_A + 64'(i) * 2, 0, 0, 0, 0, 0, 0);
         check("midrst_pred", 64'(act_taken), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
